// File: rtl/lmi_cfg_arbiter.sv
// lmi_cfg_arbiter: round-robin sharing of the HIP LMI config port, one transaction in flight.
// Define LMI_TIMEOUT_EN to force completion with an error after TIMEOUT_CYC unacked WAIT cycles.
module lmi_cfg_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                    iPLD_CLK,
  input  logic                    iRST,
  input  logic [NUM_REQ-1:0]      iREQ,
  input  logic [NUM_REQ-1:0]      iREQ_WR,
  input  logic [NUM_REQ*12-1:0]   iREQ_ADDR,
  input  logic [NUM_REQ*32-1:0]   iREQ_WDATA,
  output logic [NUM_REQ-1:0]      oDONE,
  output logic [31:0]             oRD_DATA,
  output logic                    oERR,
  output logic                    oBUSY,
  output logic [11:0]             oLMI_ADDR,
  output logic [31:0]             oLMI_DIN,
  output logic                    oLMI_RDEN,
  output logic                    oLMI_WREN,
  input  logic                    iLMI_ACK,
  input  logic [31:0]             iLMI_DOUT
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] rr, idx, pick;
  logic [NUM_REQ-1:0] last_done, eligible;
  logic is_wr, timeout, grant, finish;
  // the requester served last is masked for the IDLE cycle that follows its completion
  assign eligible = iREQ & ~last_done;
  assign grant = state == IDLE && state_nx == ISSUE;
  assign finish = state == WAIT && state_nx == DONE;
  // lowest offset from the round-robin pointer wins; descending loop lets it overwrite
  always_comb begin
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (eligible[(int'(rr) + k) % NUM_REQ]) pick = IW'((int'(rr) + k) % NUM_REQ);
  end
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    state_nx = |eligible ? ISSUE : IDLE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = (iLMI_ACK || timeout) ? DONE : WAIT;
      default: state_nx = IDLE;
    endcase
  end
`ifdef LMI_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1) > 8 ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [CW-1:0] cnt;
  always_ff @(posedge iPLD_CLK or posedge iRST) begin
    if (iRST) cnt <= '0;
    else cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
  end
  // expires on the TIMEOUT_CYC-th WAIT cycle; a coincident ack still completes cleanly
  assign timeout = state == WAIT && cnt == CW'(TIMEOUT_CYC - 1);
`else
  assign timeout = 1'b0;
`endif
  always_ff @(posedge iPLD_CLK or posedge iRST) begin
    if (iRST) begin
      state     <= IDLE;
      rr        <= '0;
      idx       <= '0;
      is_wr     <= 1'b0;
      last_done <= '0;
      oDONE     <= '0;
      oRD_DATA  <= '0;
      oERR      <= 1'b0;
      oBUSY     <= 1'b0;
      oLMI_ADDR <= '0;
      oLMI_DIN  <= '0;
      oLMI_RDEN <= 1'b0;
      oLMI_WREN <= 1'b0;
    end else begin
      state     <= state_nx;
      last_done <= oDONE;
      oBUSY     <= state_nx != IDLE;
      oLMI_RDEN <= grant && !iREQ_WR[pick];
      oLMI_WREN <= grant && iREQ_WR[pick];
      oDONE     <= state_nx == DONE ? NUM_REQ'(1) << idx : '0;
      if (grant) begin
        idx       <= pick;
        is_wr     <= iREQ_WR[pick];
        oLMI_ADDR <= iREQ_ADDR[12*pick +: 12];
        oLMI_DIN  <= iREQ_WDATA[32*pick +: 32];
      end
      if (finish) begin
        oERR <= !iLMI_ACK;
        if (!iLMI_ACK) oRD_DATA <= '1;
        else if (!is_wr) oRD_DATA <= iLMI_DOUT;
      end
      if (state == DONE) rr <= idx == IW'(NUM_REQ - 1) ? '0 : idx + 1'b1;
    end
  end
endmodule
